// File: rtl/l4_range_encoder_pkg.sv
// Shared sizing, mode encodings and FSM state codes for the L4 range encoder.
package l4_range_encoder_pkg;

  localparam int unsigned ENC_INBITS  = 16;
  localparam int unsigned ENC_OUTBITS = 4;
  localparam int unsigned CHUNK       = 4;
  localparam int unsigned NCHUNK      = ENC_INBITS / CHUNK;
  localparam int unsigned OFF_W       = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int unsigned PTR_W       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [2:0] {
    ENCODE_DISABLE = 3'b000,
    ENCODE_LOWEST  = 3'b001,
    ENCODE_HIGHEST = 3'b010,
    ENCODE_RANGE   = 3'b011,
    ENCODE_EACH    = 3'b100
  } enc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_EMIT   = 2'b10,
    ST_FINISH = 2'b11
  } enc_state_e;

  // Unused encodings 101..111 fold onto DISABLE.
  function automatic enc_mode_e decode_mode(input logic [2:0] sel);
    case (sel)
      3'b001:  return ENCODE_LOWEST;
      3'b010:  return ENCODE_HIGHEST;
      3'b011:  return ENCODE_RANGE;
      3'b100:  return ENCODE_EACH;
      default: return ENCODE_DISABLE;
    endcase
  endfunction

endpackage

// File: rtl/l4_chunk_prienc.sv
// Combinational priority encoder over one mask chunk, with run tracking so
// contiguity can be judged across chunk boundaries.
module l4_chunk_prienc #(
  parameter int unsigned CHUNK_W  = 4,
  parameter int unsigned OFF_BITS = 2
) (
  input  logic [CHUNK_W-1:0]  chunk_i,
  input  logic                run_seen_i,    // a set bit was seen in an earlier chunk
  input  logic                run_active_i,  // the bit just before this chunk was set
  output logic                any_o,
  output logic [OFF_BITS-1:0] lo_o,
  output logic [OFF_BITS-1:0] hi_o,
  output logic                brk_o,         // a set bit follows a gap after the run
  output logic                active_o       // top bit of this chunk is set
);

  logic seen_v;
  logic act_v;

  // Walk the chunk: lowest/highest offsets and run-break detection.
  always_comb begin
    any_o  = 1'b0;
    lo_o   = '0;
    hi_o   = '0;
    brk_o  = 1'b0;
    seen_v = run_seen_i;
    act_v  = run_active_i;
    for (int b = CHUNK_W - 1; b >= 0; b--) begin
      if (chunk_i[b]) lo_o = OFF_BITS'(b);
    end
    for (int b = 0; b < CHUNK_W; b++) begin
      if (chunk_i[b]) begin
        any_o = 1'b1;
        hi_o  = OFF_BITS'(b);
        if (seen_v && !act_v) brk_o = 1'b1;
        seen_v = 1'b1;
        act_v  = 1'b1;
      end else begin
        act_v = 1'b0;
      end
    end
    active_o = act_v;
  end

endmodule

// File: rtl/l4_range_encoder.sv
// L4 range encoder: recovers lowest/highest/range/each-index information from
// a captured cell mask, scanning one chunk per cycle.
module l4_range_encoder
  import l4_range_encoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [2:0]             sel_mode,
  input  logic [ENC_INBITS-1:0]  mask,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [ENC_OUTBITS-1:0] lower,
  output logic [ENC_OUTBITS-1:0] upper,
  output logic                   contiguous,
  output logic                   idx_valid,
  output logic [ENC_OUTBITS-1:0] idx,
  input  logic                   idx_ready
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCHUNK - 1);

  enc_state_e             state_q;
  enc_mode_e              mode_q;
  logic [ENC_INBITS-1:0]  work_q;
  logic [PTR_W-1:0]       ptr_q;
  logic                   run_active_q;
  logic                   busy_q, done_q, found_q, contig_q, idx_valid_q;
  logic [ENC_OUTBITS-1:0] lower_q, upper_q, idx_q;

  logic [CHUNK-1:0]       chunk_c;
  logic                   any_c, brk_c, active_c;
  logic [OFF_W-1:0]       lo_off_c, hi_off_c;
  logic [ENC_OUTBITS-1:0] lo_idx_c, hi_idx_c;
  logic                   lower_en_c, upper_en_c;

  assign chunk_c  = work_q[32'(ptr_q) * CHUNK +: CHUNK];
  assign lo_idx_c = ENC_OUTBITS'(32'(ptr_q) * CHUNK + 32'(lo_off_c));
  assign hi_idx_c = ENC_OUTBITS'(32'(ptr_q) * CHUNK + 32'(hi_off_c));

  assign lower_en_c = (mode_q == ENCODE_LOWEST)  || (mode_q == ENCODE_RANGE);
  assign upper_en_c = (mode_q == ENCODE_HIGHEST) || (mode_q == ENCODE_RANGE);

  l4_chunk_prienc #(
    .CHUNK_W  (CHUNK),
    .OFF_BITS (OFF_W)
  ) u_prienc (
    .chunk_i      (chunk_c),
    .run_seen_i   (found_q),
    .run_active_i (run_active_q),
    .any_o        (any_c),
    .lo_o         (lo_off_c),
    .hi_o         (hi_off_c),
    .brk_o        (brk_c),
    .active_o     (active_c)
  );

  // Control FSM and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= ENCODE_DISABLE;
      work_q       <= '0;
      ptr_q        <= '0;
      run_active_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      lower_q      <= '0;
      upper_q      <= '0;
      contig_q     <= 1'b0;
      idx_valid_q  <= 1'b0;
      idx_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q       <= mask;
            mode_q       <= decode_mode(sel_mode);
            ptr_q        <= '0;
            run_active_q <= 1'b0;
            found_q      <= 1'b0;
            lower_q      <= '0;
            upper_q      <= '0;
            contig_q     <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= (decode_mode(sel_mode) == ENCODE_DISABLE) ? ST_FINISH : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (mode_q == ENCODE_EACH) begin
            // Stop on the lowest remaining bit of this chunk, else move on.
            if (any_c) begin
              idx_q       <= lo_idx_c;
              idx_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end else if (ptr_q == PTR_LAST) begin
              state_q <= ST_FINISH;
            end else begin
              ptr_q <= ptr_q + PTR_W'(1);
            end
          end else begin
            // Fixed NCHUNK-cycle sweep so latency does not depend on data.
            if (any_c) begin
              found_q <= 1'b1;
              if (!found_q && lower_en_c) lower_q <= lo_idx_c;
              if (upper_en_c) upper_q <= hi_idx_c;
            end
            if (mode_q == ENCODE_RANGE) begin
              contig_q <= (contig_q || (!found_q && any_c)) && !brk_c;
            end
            run_active_q <= active_c;
            if (ptr_q == PTR_LAST) begin
              state_q <= ST_FINISH;
            end else begin
              ptr_q <= ptr_q + PTR_W'(1);
            end
          end
        end
        ST_EMIT: begin
          // Retire the emitted bit and rescan the same chunk.
          if (idx_ready) begin
            work_q[idx_q] <= 1'b0;
            idx_valid_q   <= 1'b0;
            found_q       <= 1'b1;
            state_q       <= ST_SCAN;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign lower      = lower_q;
  assign upper      = upper_q;
  assign contiguous = contig_q;
  assign idx_valid  = idx_valid_q;
  assign idx        = idx_q;

endmodule

// File: doc/l4_range_encoder.md
Name: l4_range_encoder

Overview:
- Inverse of the L4 range decoder: takes a captured ENC_INBITS-wide cell mask and recovers index information from it.
- Recoverable information: the lowest set index, the highest set index, the range plus a contiguity flag, or each set index streamed out in turn.
- Used after wavefront expansion to locate reached cells and to feed traceback.
- The mask is scanned CHUNK bits per cycle to keep the clock period short, in line with the registered-output style of the L4 datapath.

Parameters:
- ENC_INBITS, 16, mask width; must be a multiple of CHUNK.
- ENC_OUTBITS, 4, index width; 2**ENC_OUTBITS >= ENC_INBITS.
- CHUNK, 4, mask bits examined per scan cycle. NCHUNK = ENC_INBITS/CHUNK.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sel_mode  in  3  operation, captured at start.
- mask  in  ENC_INBITS  cell mask, captured at start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- found  out  1  at least one mask bit was set.
- lower  out  ENC_OUTBITS  lowest set index (LOWEST/RANGE).
- upper  out  ENC_OUTBITS  highest set index (HIGHEST/RANGE).
- contiguous  out  1  set bits form a single unbroken run (RANGE).
- idx_valid  out  1  streamed index available (EACH).
- idx  out  ENC_OUTBITS  streamed index.
- idx_ready  in  1  consumer accepts idx.

Behaviour:
- Clock is clk; reset is synchronous, active-low on reset_n.
- Reset, including mid-operation, forces IDLE and zeroes all outputs (busy, done, found, lower, upper, contiguous, idx_valid, idx) on the next edge.
- sel_mode encodings:
  - 000 ENCODE_DISABLE.
  - 001 ENCODE_LOWEST.
  - 010 ENCODE_HIGHEST.
  - 011 ENCODE_RANGE.
  - 100 ENCODE_EACH.
  - 101–111 behave as DISABLE.
- FSM states: IDLE, SCAN, EMIT, FINISH.
  - IDLE + start: capture mask into a work register and sel_mode; clear found/lower/upper/contiguous; set chunk pointer to 0; go to SCAN, or to FINISH if DISABLE.
  - SCAN for LOWEST/HIGHEST/RANGE: one chunk per cycle, ascending from chunk 0.
    - First set bit seen loads lower.
    - Every set bit updates upper.
    - A set bit seen after a 0 that followed the run clears contiguous.
    - Exactly NCHUNK SCAN cycles, with no early exit, so latency is deterministic. Then go to FINISH.
  - SCAN for EACH:
    - If the current chunk has a set bit, load idx with the lowest such index, set idx_valid, go to EMIT.
    - Otherwise advance the pointer; after the last chunk go to FINISH.
  - EMIT: hold idx/idx_valid stable until idx_ready=1.
    - On handshake, clear that bit in the work register, drop idx_valid, set found, return to SCAN on the same chunk.
    - Streaming throughput is 1 index per 2 cycles.
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- Latency from the start edge:
  - LOWEST/HIGHEST/RANGE: done high in cycle NCHUNK+1.
  - DISABLE: done in cycle 1.
  - EACH: data-dependent.
- Result outputs hold their values from done until the next accepted start.
- Boundary cases:
  - All-zero mask: found=0, lower=upper=0, contiguous=0; EACH emits nothing.
  - Single set bit: lower=upper=index, contiguous=1.
  - Bits 0 and ENC_INBITS-1 both set: indices are correct with no wrap-around.
- start while busy is ignored. Changes to mask or sel_mode while busy have no effect.
- In EMIT, idx_ready asserted before idx_valid does not count as a handshake.
- Round-trip invariant: the decoder's RANGE(l,u) output, encoded with RANGE, returns lower=l, upper=u, contiguous=1.

Decomposition:
- ENCODE_* mode constants and FSM state codes go in the shared L4_decs.v, alongside the DECODE_* constants.
- One sub-module: l4_chunk_prienc.
  - Combinational, CHUNK-wide.
  - Outputs: any, lowest offset, highest offset, plus a run-break flag given the incoming run state.
  - Instantiated once; the top adds chunk_ptr*CHUNK.

Test Plan:
- RANGE, mask=16'h0F00: after 5 cycles done=1, found=1, lower=8, upper=11, contiguous=1.
- RANGE, mask=16'h8001: lower=0, upper=15, contiguous=0. LOWEST on 16'h0000: found=0, lower=0, done at cycle 5.
- EACH, mask=16'h1024, idx_ready stalled 3 cycles on the first index: idx stream 2, 5, 12, each held stable while stalled; then done; found=1.
- Reset_n pulsed low mid-SCAN, and separately during EMIT: next cycle all outputs 0, state IDLE; a new start runs normally.
- start re-asserted while busy, mask changed during scan: ignored; result matches the originally captured mask. DISABLE and mode 111: done at cycle 1, found=0.
- Random round-trip: random l<=u drives the decoder in RANGE mode; its output feeds the encoder; check lower=l, upper=u, contiguous=1 over 1000 trials.
